// File: rtl/sdram_pkg.sv
// Shared SDRAM init definitions: command encodings, sequencer states, default mode word.
// Consumed by sdram_init_seq; the SDRAM_INIT_REFRESH_EN build adds sdram_refresh_timer.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_INHIBIT      = 4'b1111;
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

  // CAS latency 3, sequential bursts, burst length 4
  localparam logic [12:0] MODE_DEFAULT = 13'h032;

  typedef enum logic [2:0] {
    S_WAIT_PWR,
    S_PRECHARGE,
    S_WAIT_RP,
    S_REFRESH,
    S_WAIT_RFC,
    S_LOAD_MODE,
    S_WAIT_MRD,
    S_DONE
  } init_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh request: free-running T_REFI counter, request held until acknowledged.
// Built only when SDRAM_INIT_REFRESH_EN is defined; a terminal count beats a same-cycle ack.
module sdram_refresh_timer #(
  parameter int T_REFI = 780
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ref_ack,
  output logic ref_req
);

  localparam int TW = $clog2(T_REFI + 1);
  localparam logic [TW-1:0] TC_VAL = TW'(T_REFI - 1);

  logic [TW-1:0] cnt;
  logic          tc;

  assign tc = en && (cnt == TC_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      ref_req <= 1'b0;
    end else begin
      if (en) cnt <= tc ? '0 : cnt + TW'(1);
      // Requests do not queue: a second terminal count just keeps the flag high.
      ref_req <= tc | (ref_req & ~ref_ack);
    end
  end

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: NOP wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE, then init_done.
// Optional periodic refresh request via SDRAM_INIT_REFRESH_EN; all outputs registered.
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int          T_POWERUP     = 20000,
  parameter int          T_RP          = 2,
  parameter int          T_RFC         = 7,
  parameter int          REFRESH_COUNT = 8,
  parameter int          T_MRD         = 2,
  parameter logic [12:0] MODE_VALUE    = MODE_DEFAULT,
  parameter int          T_REFI        = 780
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        sdram_cke,
  output logic [3:0]  sdram_cmd,
  output logic [12:0] sdram_addr,
  output logic [1:0]  sdram_ba,
  output logic        init_done,
  output logic        ref_req,
  input  logic        ref_ack
);

  localparam int CNT_MAX = max4(T_POWERUP, T_RP, T_RFC, T_MRD);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(REFRESH_COUNT + 1);

  // Command states preload spacing-1 so a spacing of 1 skips the wait state.
  localparam logic [CW-1:0] LD_PWR  = CW'(T_POWERUP);
  localparam logic [CW-1:0] LD_RP   = CW'(T_RP - 1);
  localparam logic [CW-1:0] LD_RFC  = CW'(T_RFC - 1);
  localparam logic [CW-1:0] LD_MRD  = CW'(T_MRD - 1);
  localparam logic [RW-1:0] RC_LAST = RW'(REFRESH_COUNT);

  init_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] ref_cnt, ref_cnt_nxt;
  logic [3:0]    cmd_nxt;
  logic [12:0]   addr_nxt;
  logic          done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_WAIT_PWR;
      cnt        <= LD_PWR;
      ref_cnt    <= '0;
      sdram_cke  <= 1'b0;
      sdram_cmd  <= CMD_INHIBIT;
      sdram_addr <= '0;
      sdram_ba   <= '0;
      init_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ref_cnt    <= ref_cnt_nxt;
      sdram_cke  <= 1'b1;
      sdram_cmd  <= cmd_nxt;
      sdram_addr <= addr_nxt;
      sdram_ba   <= '0;
      init_done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ref_cnt_nxt = ref_cnt;
    case (state)
      S_WAIT_PWR: begin
        if (cnt == '0) begin
          state_nxt = S_PRECHARGE;
          cnt_nxt   = LD_RP;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_PRECHARGE, S_WAIT_RP: begin
        if (cnt == '0) begin
          state_nxt   = S_REFRESH;
          cnt_nxt     = LD_RFC;
          ref_cnt_nxt = ref_cnt + RW'(1);
        end else begin
          state_nxt = S_WAIT_RP;
          cnt_nxt   = cnt - CW'(1);
        end
      end
      S_REFRESH, S_WAIT_RFC: begin
        if (cnt != '0) begin
          state_nxt = S_WAIT_RFC;
          cnt_nxt   = cnt - CW'(1);
        end else if (ref_cnt == RC_LAST) begin
          state_nxt = S_LOAD_MODE;
          cnt_nxt   = LD_MRD;
        end else begin
          state_nxt   = S_REFRESH;
          cnt_nxt     = LD_RFC;
          ref_cnt_nxt = ref_cnt + RW'(1);
        end
      end
      S_LOAD_MODE, S_WAIT_MRD: begin
        if (cnt == '0) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_WAIT_MRD;
          cnt_nxt   = cnt - CW'(1);
        end
      end
      S_DONE: state_nxt = S_DONE;
      default: begin
        state_nxt = S_WAIT_PWR;
        cnt_nxt   = LD_PWR;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered bus lines up with the state.
  always_comb begin
    cmd_nxt  = CMD_NOP;
    addr_nxt = '0;
    done_nxt = 1'b0;
    case (state_nxt)
      S_PRECHARGE: begin
        cmd_nxt  = CMD_PRECHARGE;
        addr_nxt = 13'h0400;
      end
      S_REFRESH:   cmd_nxt = CMD_AUTO_REFRESH;
      S_LOAD_MODE: begin
        cmd_nxt  = CMD_LOAD_MODE;
        addr_nxt = MODE_VALUE;
      end
      S_DONE:      done_nxt = 1'b1;
      default:     ;
    endcase
  end

`ifdef SDRAM_INIT_REFRESH_EN
  sdram_refresh_timer #(
    .T_REFI (T_REFI)
  ) u_refresh_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (init_done),
    .ref_ack (ref_ack),
    .ref_req (ref_req)
  );
`else
  wire unused_ref = ref_ack ^ T_REFI[0];
  assign ref_req = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for sdram_init_seq: spec-timing table, formula-based model with random resets/acks.
// Refresh-request checks follow SDRAM_INIT_REFRESH_EN as compiled.
module tb_sdram_init_seq;

  localparam int T_POWERUP = 10, T_RP = 2, T_RFC = 3, REFRESH_COUNT = 2, T_MRD = 2, T_REFI = 5;
  localparam int P = T_POWERUP + 1;
  localparam int L = P + T_RP + REFRESH_COUNT * T_RFC;
  localparam int D = L + T_MRD;

  localparam logic [3:0]  C_INH = 4'b1111, C_NOP = 4'b0111, C_PRE = 4'b0010;
  localparam logic [3:0]  C_AR = 4'b0001, C_LMR = 4'b0000;
  localparam logic [12:0] MODE = 13'h032;
  localparam logic [21:0] RST_VAL = {1'b0, C_INH, 13'h0, 2'b00, 1'b0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ref_ack;
  logic        sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic        init_done;
  logic        ref_req;

  sdram_init_seq #(
    .T_POWERUP     (T_POWERUP),
    .T_RP          (T_RP),
    .T_RFC         (T_RFC),
    .REFRESH_COUNT (REFRESH_COUNT),
    .T_MRD         (T_MRD),
    .MODE_VALUE    (MODE),
    .T_REFI        (T_REFI)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sdram_cke  (sdram_cke),
    .sdram_cmd  (sdram_cmd),
    .sdram_addr (sdram_addr),
    .sdram_ba   (sdram_ba),
    .init_done  (init_done),
    .ref_req    (ref_req),
    .ref_ack    (ref_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int run_id = 0;
  int n_ar;
  logic [21:0] seen [0:63];

  typedef struct {
    int          cyc;
    logic        cke;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        done;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [21:0] obs();
    return {sdram_cke, sdram_cmd, sdram_addr, sdram_ba, init_done, ref_req};
  endfunction

  // Expected {cke, cmd, addr, ba, init_done} at cycle k after release, from the timing formulas.
  function automatic logic [20:0] exp_bus(input int k);
    logic [3:0]  c;
    logic [12:0] a;
    c = C_NOP;
    a = '0;
    if (k == 0) return RST_VAL[21:1];
    if (k == P) begin
      c = C_PRE;
      a = 13'h0400;
    end else if (k == L) begin
      c = C_LMR;
      a = MODE;
    end else if (k >= P + T_RP && k < L && ((k - P - T_RP) % T_RFC) == 0) begin
      c = C_AR;
    end
    return {1'b1, c, a, 2'b00, (k >= D)};
  endfunction

  // Release reset, run ncyc cycles against the model, then assert reset mid-cycle.
  // mode: 0 no ack, 1 directed ack at cycles 32/33/40, 2 random ack.
  task automatic run(input int ncyc, input int mode);
    logic req_m, ack_prev, tc;
    req_m    = 1'b0;
    ack_prev = 1'b0;
    n_ar     = 0;
    for (int i = 0; i < 64; i++) seen[i] = '0;
    @(negedge clk);
    ref_ack = 1'b0;
    rst_n   = 1'b1;
    #1 check($sformatf("run%0d_cyc0", run_id), obs(), RST_VAL);
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      #1;
      seen[k] = obs();
      tc = (k > D) && (((k - D) % T_REFI) == 0);
`ifdef SDRAM_INIT_REFRESH_EN
      req_m = tc | (req_m & ~ack_prev);
`else
      req_m = 1'b0;
`endif
      check($sformatf("run%0d_cyc%0d", run_id, k), obs(), {exp_bus(k), req_m});
      if (sdram_cmd == C_AR) n_ar++;
      case (mode)
        0:       ref_ack = 1'b0;
        1:       ref_ack = (k == 32) || (k == 33) || (k == 40);
        default: ref_ack = ($urandom_range(0, 2) == 0);
      endcase
      ack_prev = ref_ack;
    end
    #2;
    rst_n   = 1'b0;
    ref_ack = 1'b0;
    #1 check($sformatf("run%0d_async_rst", run_id), obs(), RST_VAL);
    run_id++;
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 13; i++)
      check($sformatf("%s_cyc%0d", tag, tbl[i].cyc), seen[tbl[i].cyc][21:1],
            {tbl[i].cke, tbl[i].cmd, tbl[i].addr, 2'b00, tbl[i].done});
  endtask

  initial begin
    tbl[0]  = '{1,  1'b1, C_NOP, 13'h0000, 1'b0};
    tbl[1]  = '{5,  1'b1, C_NOP, 13'h0000, 1'b0};
    tbl[2]  = '{10, 1'b1, C_NOP, 13'h0000, 1'b0};
    tbl[3]  = '{11, 1'b1, C_PRE, 13'h0400, 1'b0};
    tbl[4]  = '{12, 1'b1, C_NOP, 13'h0000, 1'b0};
    tbl[5]  = '{13, 1'b1, C_AR,  13'h0000, 1'b0};
    tbl[6]  = '{14, 1'b1, C_NOP, 13'h0000, 1'b0};
    tbl[7]  = '{16, 1'b1, C_AR,  13'h0000, 1'b0};
    tbl[8]  = '{17, 1'b1, C_NOP, 13'h0000, 1'b0};
    tbl[9]  = '{19, 1'b1, C_LMR, 13'h0032, 1'b0};
    tbl[10] = '{20, 1'b1, C_NOP, 13'h0000, 1'b0};
    tbl[11] = '{21, 1'b1, C_NOP, 13'h0000, 1'b1};
    tbl[12] = '{30, 1'b1, C_NOP, 13'h0000, 1'b1};

    rst_n   = 1'b0;
    ref_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", obs(), RST_VAL);

    run(30, 0);
    check_table("tbl_first");

    // Interrupted at cycle 15, then a full replay must show exactly REFRESH_COUNT refreshes.
    run(15, 0);
    run(30, 0);
    check_table("tbl_replay");
    check("ar_count", n_ar, REFRESH_COUNT);

    run(45, 1);
`ifdef SDRAM_INIT_REFRESH_EN
    check("req_before_tc", seen[25][0], 1'b0);
    check("req_first_tc",  seen[26][0], 1'b1);
    check("req_held_tc31", seen[31][0], 1'b1);
    check("req_pre_ack",   seen[32][0], 1'b1);
    check("req_acked",     seen[33][0], 1'b0);
    check("ack_ignored",   seen[34][0], 1'b0);
    check("req_tc36",      seen[36][0], 1'b1);
    check("tc_beats_ack",  seen[41][0], 1'b1);
    check("req_after_tie", seen[42][0], 1'b1);
`else
    check("req_off_tc26", seen[26][0], 1'b0);
    check("req_off_tc41", seen[41][0], 1'b0);
`endif

    for (int it = 0; it < 20; it++) run($urandom_range(1, 50), 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
